dmem_responder: RTL and testbench

Responder end of the datapath's data-memory interface: accepts one load or store request at a time from the MEM stage over a valid/ready handshake. It performs byte/half/word lane steering and load sign/zero extension internally. It models a fixed number of wait states and returns a single-cycle response pulse. It sits behind the MEM stage of the pipelined core and exposes `busy` so the hazard logic can stall the front of the pipe.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 69 ++++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and
// the helper that sizes the word index.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory: byte enables, replicated store
// word, extended load data. Misalignment detection exists only with DMEM_MISALIGN_TRAP_EN.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    assign half_s = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Pick the addressed byte lane of the read word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = rword[7:0];
            2'd1:    byte_s = rword[15:8];
            2'd2:    byte_s = rword[23:16];
            default: byte_s = rword[31:24];
        endcase
    end

    // Enables, store replication and load extension; size 11 behaves as a word.
    always_comb begin
        byte_en   = 4'hF;
        wword     = wdata;
        rdata_ext = rword;
        case (size)
            SZ_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword     = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & half_s[15]}}, half_s};
            end
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wword     = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & byte_s[7]}}, byte_s};
            end
            default: begin
                byte_en   = 4'hF;
                wword     = wdata;
                rdata_ext = rword;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Half must be 2-byte aligned, word 4-byte aligned; bytes are always aligned.
    always_comb begin
        case (size)
            SZ_HALF: misaligned = addr_lo[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = (addr_lo != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, one-cycle
// response pulse. Optional misalignment trap under DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               wr_r, uns_r;
    logic [1:0]         size_r;
    logic [IDX_W+1:0]   addr_r;
    logic [31:0]        wdata_r;
    logic [31:0]        rdata_r;
    logic               err_r;
    logic [31:0]        mem_r [DEPTH_WORDS];

    logic               idle_s, accept_s, enter_resp_s;
    logic               cur_write_s, cur_uns_s;
    logic [1:0]         cur_size_s;
    logic [IDX_W+1:0]   cur_addr_s;
    logic [31:0]        cur_wdata_s;
    logic [IDX_W-1:0]   cur_idx_s;
    logic [31:0]        rword_s, wword_s, rdata_ext_s;
    logic [3:0]         byte_en_s;
    logic               mis_s;
    logic               unused_addr_s;

    assign idle_s        = (state_r == ST_IDLE);
    assign accept_s      = req_valid & idle_s;
    assign enter_resp_s  = (state_nx_s == ST_RESP) && (state_r != ST_RESP);
    assign unused_addr_s = ^req_addr[31:IDX_W+2];

    // With zero wait states RESP is entered straight from IDLE, before the request
    // registers hold the fields, so the live inputs are used in that cycle.
    assign cur_write_s = idle_s ? req_write               : wr_r;
    assign cur_uns_s   = idle_s ? req_unsigned            : uns_r;
    assign cur_size_s  = idle_s ? req_size                : size_r;
    assign cur_addr_s  = idle_s ? req_addr[IDX_W+1:0]     : addr_r;
    assign cur_wdata_s = idle_s ? req_wdata               : wdata_r;
    assign cur_idx_s   = cur_addr_s[IDX_W+1:2];
    assign rword_s     = mem_r[cur_idx_s];

    dmem_lane_align u_lane_align (
        .size        (cur_size_s),
        .addr_lo     (cur_addr_s[1:0]),
        .is_unsigned (cur_uns_s),
        .wdata       (cur_wdata_s),
        .rword       (rword_s),
        .byte_en     (byte_en_s),
        .wword       (wword_s),
        .rdata_ext   (rdata_ext_s),
        .misaligned  (mis_s)
    );

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_nx_s = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                else           state_nx_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_r == '0) state_nx_s = ST_RESP;
                else             state_nx_s = ST_WAIT;
            end
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, wait counter, captured request and response registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            wr_r    <= 1'b0;
            uns_r   <= 1'b0;
            size_r  <= SZ_WORD;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                cnt_r   <= CNT_LOAD;
                wr_r    <= req_write;
                uns_r   <= req_unsigned;
                size_r  <= req_size;
                addr_r  <= req_addr[IDX_W+1:0];
                wdata_r <= req_wdata;
            end else if (state_r == ST_WAIT && cnt_r != '0) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
            if (enter_resp_s) begin
                rdata_r <= (cur_write_s || mis_s) ? 32'h0000_0000 : rdata_ext_s;
`ifdef DMEM_MISALIGN_TRAP_EN
                err_r   <= mis_s;
`else
                err_r   <= 1'b0;
`endif
            end
        end
    end

    // Byte-masked store on the edge entering RESP; contents survive reset.
    always_ff @(posedge Clk) begin
        if (!Reset && enter_resp_s && cur_write_s && !mis_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) mem_r[cur_idx_s][8*b +: 8] <= wword_s[8*b +: 8];
            end
        end
    end

    assign req_ready = idle_s;
    assign busy      = ~idle_s;
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized traffic
// against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int DEPTH = 128;
    localparam int WS    = 2;
    localparam int NB    = DEPTH * 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] mb [NB];
    bit         mk [NB];

    always #5 Clk = ~Clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (a % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_reset_outputs(input string tag);
        check_val({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check_val({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_val({tag, "_rdata"}, rsp_rdata, 32'd0);
        check_val({tag, "_err"},   {31'd0, rsp_err}, 32'd0);
        check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    // One complete transaction; optionally keeps req_valid high with a junk store
    // while the block is busy. Checks latency, busy length and the response fields.
    task automatic do_req(input bit w, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit hold, output logic [31:0] rd);
        int n, g, lat, busyc;
        int unsigned base;
        bit known, mis;
        logic [31:0] exp_v;
        @(negedge Clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        g = 0;
        while (!req_ready && g < 20) begin @(negedge Clk); g++; end
        check_val("ready_wait", g, 0);
        @(posedge Clk);
        #1;
        if (hold) begin
            req_write = 1'b1; req_size = 2'b00; req_addr = 32'h34; req_wdata = 32'h5555_5555;
        end else begin
            req_valid = 1'b0;
        end
        lat = 0; busyc = 0;
        while (lat < 20) begin
            @(negedge Clk);
            lat++;
            if (busy) busyc++;
            if (rsp_valid) break;
        end
        req_valid = 1'b0;
        check_val("latency", lat, WS + 1);
        check_val("busy_len", busyc, WS + 1);
        rd = rsp_rdata;

        n = nbytes(sz);
        base = ((a / n) * n) % NB;
        mis = is_mis(sz, a);
        known = 1'b1;
        exp_v = 32'd0;
        if (mis) begin
            check_val("err", {31'd0, rsp_err}, 32'd1);
            check_val("rdata_mis", rsp_rdata, 32'd0);
        end else if (w) begin
            for (int i = 0; i < n; i++) begin
                mb[base + i] = wd[8*i +: 8];
                mk[base + i] = 1'b1;
            end
            check_val("err", {31'd0, rsp_err}, 32'd0);
            check_val("rdata_st", rsp_rdata, 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_v = exp_v | (32'(mb[base + i]) << (8 * i));
                known = known & mk[base + i];
            end
            if (!uns && n < 4 && exp_v[8*n-1]) exp_v = exp_v | (32'hFFFF_FFFF << (8 * n));
            check_val("err", {31'd0, rsp_err}, 32'd0);
            if (known) check_val("rdata_ld", rsp_rdata, exp_v);
        end
        @(negedge Clk);
        check_val("pulse_end", {31'd0, rsp_valid}, 32'd0);
        check_val("rdata_hold", rsp_rdata, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsz;
        logic [31:0] ra;
        for (int i = 0; i < NB; i++) begin mb[i] = 8'h00; mk[i] = 1'b0; end
        Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk_reset_outputs("rst_during");
        Reset = 1'b0;
        @(negedge Clk);
        chk_reset_outputs("rst_after");

        do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, rd);
        check_val("tp_word", rd, 32'hDEAD_BEEF);
        do_req(1'b1, 2'b10, 1'b0, 32'h13, 32'h0000_007F, 1'b0, rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, rd);
        check_val("tp_byte_st", rd, 32'h7FAD_BEEF);

        do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_8081, 1'b0, rd);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, rd);
        check_val("tp_lb", rd, 32'hFFFF_FF81);
        do_req(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 1'b0, rd);
        check_val("tp_lbu", rd, 32'h0000_0081);
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, rd);
        check_val("tp_lh", rd, 32'hFFFF_8081);

        do_req(1'b1, 2'b00, 1'b0, 32'h200, 32'h1234_5678, 1'b0, rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h000, 32'h0, 1'b0, rd);
        check_val("tp_wrap", rd, 32'h1234_5678);

        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h1111_1111, 1'b0, rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
        check_val("tp_mis", rd, 32'h0000_8081);
`else
        check_val("tp_mis", rd, 32'h1111_1111);
`endif

        // req_valid held through the busy period must not start a second request.
        do_req(1'b1, 2'b00, 1'b0, 32'h34, 32'h0000_0000, 1'b0, rd);
        do_req(1'b1, 2'b00, 1'b0, 32'h30, 32'hAAAA_AAAA, 1'b1, rd);
        do_req(1'b0, 2'b00, 1'b0, 32'h34, 32'h0, 1'b0, rd);
        check_val("tp_hold", rd, 32'h0000_0000);

        // Reset while a store is in WAIT drops the store.
        do_req(1'b1, 2'b00, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0, rd);
        @(negedge Clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h40;
        req_wdata = 32'h0BAD_BEEF;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        @(negedge Clk);
        check_val("mid_busy", {31'd0, busy}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        chk_reset_outputs("rst_wait");
        Reset = 1'b0;
        do_req(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 1'b0, rd);
        check_val("tp_rst_store", rd, 32'hCAFE_F00D);

        for (int t = 0; t < 120; t++) begin
            rsz = 2'($urandom_range(0, 3));
            ra  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            do_req(($urandom_range(0, 2) == 0), rsz, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
